// File: rtl/aes_pkg.sv
// Shared AES definitions: round constants, round count, scheduler state
// encoding and the bit ranges of the four 32-bit words inside a 128-bit key.
package aes_pkg;

    localparam int AES_NR = 10;

    // w0 is the most significant word, matching FIPS-197 byte order.
    localparam int W0_MSB = 127;
    localparam int W0_LSB = 96;
    localparam int W1_MSB = 95;
    localparam int W1_LSB = 64;
    localparam int W2_MSB = 63;
    localparam int W2_LSB = 32;
    localparam int W3_MSB = 31;
    localparam int W3_LSB = 0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Rcon[0] is never used by the schedule; it returns zero.
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box; shared by the encrypt and inverse key
// schedules.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Entry 0 sits in the top byte, so entry x starts at bit 8*(255-x).
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] w_base;

    assign w_base = {~i_byte, 3'b000};
    assign o_byte = SBOX_FLAT[w_base +: 8];

endmodule

// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 inverse key schedule: emits round keys 10 down to 0,
// one per valid/ready transfer, from the round-10 key alone.
module aes_inv_key_sched
    import aes_pkg::*;
#(
    parameter int KEY_W = 128,
    parameter int NR    = AES_NR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] last_key,
    output logic             ready,
    output logic [KEY_W-1:0] key_out,
    output logic [3:0]       round_idx,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             done,
    output state_t           o_dbg_state
);

    // Handshake: a key transfers on any rising edge where key_valid && key_ready.
    // While key_valid is high and key_ready is low, key_out/round_idx hold.
    // key_valid never drops without a transfer except on rst.

    state_t           r_state;
    logic             r_ready;
    logic             r_valid;
    logic             r_done;
    logic [KEY_W-1:0] r_key;
    logic [3:0]       r_round;

    logic [31:0]      w_w0;
    logic [31:0]      w_w1;
    logic [31:0]      w_w2;
    logic [31:0]      w_w3;
    logic [31:0]      w_p0;
    logic [31:0]      w_p1;
    logic [31:0]      w_p2;
    logic [31:0]      w_p3;
    logic [31:0]      w_rot;
    logic [31:0]      w_sub;
    logic [KEY_W-1:0] w_next;

    assign w_w0 = r_key[W0_MSB:W0_LSB];
    assign w_w1 = r_key[W1_MSB:W1_LSB];
    assign w_w2 = r_key[W2_MSB:W2_LSB];
    assign w_w3 = r_key[W3_MSB:W3_LSB];

    // Undo the forward recurrence w[i] = w[i-4] ^ w[i-1] for the upper three
    // words; p3 is the previous round's last word, which feeds SubWord.
    assign w_p3  = w_w3 ^ w_w2;
    assign w_p2  = w_w2 ^ w_w1;
    assign w_p1  = w_w1 ^ w_w0;
    assign w_rot = {w_p3[23:0], w_p3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    assign w_p0   = w_w0 ^ w_sub ^ {rcon(r_round), 24'h000000};
    assign w_next = {w_p0, w_p1, w_p2, w_p3};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_key   <= '0;
            r_round <= 4'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_ready <= 1'b0;
                        r_valid <= 1'b1;
                        r_key   <= last_key;
                        r_round <= 4'(NR);
                    end
                end
                RUN: begin
                    if (key_ready) begin
                        if (r_round == 4'd0) begin
                            r_state <= IDLE;
                            r_ready <= 1'b1;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_key   <= w_next;
                            r_round <= r_round - 4'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready       = r_ready;
    assign key_valid   = r_valid;
    assign done        = r_done;
    assign key_out     = r_key;
    assign round_idx   = r_round;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench for aes_inv_key_sched: a forward key-expansion model
// fills an expected queue that is compared against every transferred key.
module tb_aes_inv_key_sched;

    localparam logic [127:0] A1_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] A1_R9    = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] A1_R1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_R10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic            clk;
    logic            rst;
    logic            start;
    logic [127:0]    last_key;
    logic            ready;
    logic [127:0]    key_out;
    logic [3:0]      round_idx;
    logic            key_valid;
    logic            key_ready;
    logic            done;
    aes_pkg::state_t dbg_state;

    int tests_run;
    int tests_failed;

    logic [131:0] exp_q[$];
    logic [127:0] model_rk [0:10];
    logic [7:0]   sbox_tb  [0:255];

    aes_inv_key_sched dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .last_key    (last_key),
        .ready       (ready),
        .key_out     (key_out),
        .round_idx   (round_idx),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .done        (done),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box derived from the GF(2^8) inverse and affine map, not a table.
    task automatic build_sbox();
        logic [7:0] xb;
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            xb  = x[7:0];
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gf_mul(inv, xb);
            sbox_tb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                       ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tb[w[31:24]], sbox_tb[w[23:16]], sbox_tb[w[15:8]], sbox_tb[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        w[0] = key[127:96];
        w[1] = key[95:64];
        w[2] = key[63:32];
        w[3] = key[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- driver ----------------
    // Caller is at a negedge with the DUT idle; returns at the negedge of the
    // first key-valid cycle with the expected keys queued, round 10 first.
    task automatic start_schedule(input logic [127:0] cipher_key);
        expand_key(cipher_key);
        for (int r = 10; r >= 0; r--) exp_q.push_back({4'(r), model_rk[r]});
        start    = 1'b1;
        last_key = model_rk[10];
        @(negedge clk);
        start    = 1'b0;
        last_key = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (ready !== 1'b1 || key_valid !== 1'b0 || done !== 1'b0 || key_out !== 128'h0
            || round_idx !== 4'd0 || dbg_state !== aes_pkg::IDLE) begin
            tests_failed++;
            $display("FAIL reset_values: ready=%b valid=%b done=%b key=%h idx=%0d, required 1 0 0 0 0",
                     ready, key_valid, done, key_out, round_idx);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (ready !== 1'b1 || key_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_hold: ready=%b valid=%b, required 1 0", ready, key_valid);
        end
    endtask

    task automatic test_fips_a1();
        int cyc;
        logic [131:0] exp;
        key_ready = 1'b1;
        start_schedule(A1_KEY);
        tests_run++;
        if (key_valid !== 1'b1 || round_idx !== 4'd10 || key_out !== A1_R10 || ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL a1_first: valid=%b idx=%0d key=%h ready=%b, required 1 10 %h 0",
                     key_valid, round_idx, key_out, ready, A1_R10);
        end
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            tests_run++;
            if (key_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL a1_bubble: key_valid=%b at cycle %0d, required 1", key_valid, cyc);
            end else begin
                exp = exp_q.pop_front();
                if ({round_idx, key_out} !== exp) begin
                    tests_failed++;
                    $display("FAIL a1_key: got %0d:%h required %0d:%h", round_idx, key_out, exp[131:128], exp[127:0]);
                end
                if (round_idx === 4'd9 || round_idx === 4'd1 || round_idx === 4'd0) begin
                    tests_run++;
                    if (key_out !== (round_idx === 4'd9 ? A1_R9 : round_idx === 4'd1 ? A1_R1 : A1_KEY)) begin
                        tests_failed++;
                        $display("FAIL a1_vector: round %0d got %h", round_idx, key_out);
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (cyc != 11 || done !== 1'b1 || ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL a1_done: cycles=%0d done=%b ready=%b, required 11 1 1", cyc, done, ready);
            exp_q.delete();
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        logic hold;
        logic [127:0] prev_key;
        logic [3:0] prev_idx;
        logic [131:0] exp;
        hold = 1'b0;
        prev_key = '0;
        prev_idx = '0;
        start_schedule(A1_KEY);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 300) begin
            if (hold) begin
                tests_run++;
                if (key_out !== prev_key || round_idx !== prev_idx) begin
                    tests_failed++;
                    $display("FAIL bp_hold: got %0d:%h required %0d:%h", round_idx, key_out, prev_idx, prev_key);
                end
            end
            tests_run++;
            if (done !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_early_done: done=%b, required 0", done);
            end
            key_ready = ($urandom_range(0, 1) == 1);
            if (key_valid === 1'b1 && key_ready) begin
                exp = exp_q.pop_front();
                tests_run++;
                if ({round_idx, key_out} !== exp) begin
                    tests_failed++;
                    $display("FAIL bp_key: got %0d:%h required %0d:%h", round_idx, key_out, exp[131:128], exp[127:0]);
                end
            end
            hold     = (key_valid === 1'b1) && !key_ready;
            prev_key = key_out;
            prev_idx = round_idx;
            @(negedge clk);
            cyc++;
        end
        key_ready = 1'b1;
        tests_run++;
        if (exp_q.size() != 0 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_done: pending=%0d done=%b, required 0 1", exp_q.size(), done);
            exp_q.delete();
        end
    endtask

    task automatic test_start_busy();
        int cyc;
        logic injected;
        logic [131:0] exp;
        injected  = 1'b0;
        key_ready = 1'b1;
        start_schedule({$urandom(), $urandom(), $urandom(), $urandom()});
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 30) begin
            if (round_idx === 4'd6 && !injected) begin
                start    = 1'b1;
                last_key = {$urandom(), $urandom(), $urandom(), $urandom()};
                injected = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (key_valid === 1'b1) begin
                exp = exp_q.pop_front();
                tests_run++;
                if ({round_idx, key_out} !== exp) begin
                    tests_failed++;
                    $display("FAIL busy_key: got %0d:%h required %0d:%h", round_idx, key_out, exp[131:128], exp[127:0]);
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        tests_run++;
        if (exp_q.size() != 0 || done !== 1'b1 || key_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_done: pending=%0d done=%b valid=%b, required 0 1 0", exp_q.size(), done, key_valid);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        logic [131:0] exp;
        key_ready = 1'b1;
        start_schedule({$urandom(), $urandom(), $urandom(), $urandom()});
        cyc = 0;
        while (round_idx !== 4'd4 && cyc < 20) begin
            exp = exp_q.pop_front();
            tests_run++;
            if ({round_idx, key_out} !== exp) begin
                tests_failed++;
                $display("FAIL rstmid_key: got %0d:%h required %0d:%h", round_idx, key_out, exp[131:128], exp[127:0]);
            end
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        tests_run++;
        if (cyc != 6 || key_valid !== 1'b0 || ready !== 1'b1 || key_out !== 128'h0
            || round_idx !== 4'd0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_state: cyc=%0d valid=%b ready=%b key=%h idx=%0d done=%b, required 6 0 1 0 0 0",
                     cyc, key_valid, ready, key_out, round_idx, done);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [131:0] exp;
        key_ready = 1'b1;
        for (int run = 0; run < 2; run++) begin
            start_schedule(run == 0 ? A1_KEY : C1_KEY);
            if (run == 1) begin
                tests_run++;
                if (key_valid !== 1'b1 || round_idx !== 4'd10 || key_out !== C1_R10) begin
                    tests_failed++;
                    $display("FAIL b2b_accept: valid=%b idx=%0d key=%h, required 1 10 %h",
                             key_valid, round_idx, key_out, C1_R10);
                end
            end
            cyc = 0;
            while (exp_q.size() != 0 && cyc < 20) begin
                if (key_valid === 1'b1) begin
                    exp = exp_q.pop_front();
                    tests_run++;
                    if ({round_idx, key_out} !== exp) begin
                        tests_failed++;
                        $display("FAIL b2b_key: got %0d:%h required %0d:%h", round_idx, key_out, exp[131:128], exp[127:0]);
                    end
                    if (run == 1 && round_idx === 4'd0) begin
                        tests_run++;
                        if (key_out !== C1_KEY) begin
                            tests_failed++;
                            $display("FAIL b2b_round0: got %h required %h", key_out, C1_KEY);
                        end
                    end
                end
                @(negedge clk);
                cyc++;
            end
            tests_run++;
            if (exp_q.size() != 0 || done !== 1'b1 || ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_done: pending=%0d done=%b ready=%b, required 0 1 1", exp_q.size(), done, ready);
                exp_q.delete();
            end
        end
    endtask

    task automatic test_random();
        int cyc;
        int fails_before;
        logic [131:0] exp;
        fails_before = tests_failed;
        for (int n = 0; n < 1000; n++) begin
            key_ready = 1'b1;
            start_schedule({$urandom(), $urandom(), $urandom(), $urandom()});
            cyc = 0;
            while (exp_q.size() != 0 && cyc < 60) begin
                key_ready = ($urandom_range(0, 3) != 0);
                if (key_valid === 1'b1 && key_ready) begin
                    exp = exp_q.pop_front();
                    tests_run++;
                    if ({round_idx, key_out} !== exp && tests_failed - fails_before < 20) begin
                        tests_failed++;
                        $display("FAIL rand_key: got %0d:%h required %0d:%h", round_idx, key_out, exp[131:128], exp[127:0]);
                    end else if ({round_idx, key_out} !== exp) begin
                        tests_failed++;
                    end
                end
                @(negedge clk);
                cyc++;
            end
            tests_run++;
            if (exp_q.size() != 0 || done !== 1'b1) begin
                tests_failed++;
                $display("FAIL rand_done: key %0d pending=%0d done=%b, required 0 1", n, exp_q.size(), done);
                exp_q.delete();
                key_ready = 1'b1;
                repeat (15) @(negedge clk);
            end
        end
        key_ready = 1'b1;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        start        = 1'b0;
        last_key     = '0;
        key_ready    = 1'b0;
        build_sbox();
        @(negedge clk);
        test_reset();
        test_fips_a1();
        test_backpressure();
        test_start_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
